dmac_main_ctrl: RTL and testbench

Control unit for the two-channel DMAC main datapath.
- Accepts peripheral requests and selects one channel.
- Acquires the AHB bus.
- Fetches the four configuration words (SAddr, DAddr, Size, Ctrl) from the peripheral's config window at offsets 0xA0..0xAC.
- Enables the selected channel, waits for its interrupt, then releases the bus.
- Handles one request at a time. Drives every enable/select input of the datapath.

---
 rtl/dmac_ctrl_pkg.sv | 30 +++
 rtl/dmac_main_ctrl_if.sv | 19 +
 rtl/dmac_main_ctrl_req_arb.sv | 16 +
 rtl/dmac_main_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_dmac_main_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmac_ctrl_pkg.sv
// Shared types and encodings for the DMAC main control unit.
package dmac_ctrl_pkg;

  localparam int CFG_WORDS = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BUS_REQ  = 3'd1,
    CFG_ADDR = 3'd2,
    CFG_DATA = 3'd3,
    CHECK    = 3'd4,
    XFER     = 3'd5,
    DONE     = 3'd6
  } dmac_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  localparam logic [1:0] CON_SEL_CH1 = 2'b00;
  localparam logic [1:0] CON_SEL_CH2 = 2'b01;
  localparam logic [1:0] CON_SEL_CFG = 2'b10;

  localparam logic [1:0] CFG_IDX_SADDR = 2'd0;
  localparam logic [1:0] CFG_IDX_DADDR = 2'd1;
  localparam logic [1:0] CFG_IDX_SIZE  = 2'd2;
  localparam logic [1:0] CFG_IDX_CTRL  = 2'd3;
  localparam logic [1:0] CFG_IDX_LAST  = 2'(CFG_WORDS - 1);

endpackage

// File: rtl/dmac_main_ctrl_if.sv
// AHB-side handshake signals between the DMAC control unit and the bus.
interface dmac_main_ctrl_if;
  logic       HReady;
  logic [1:0] M_HResp;
  logic       Bus_Grant;
  logic       Bus_Req;
  logic [1:0] config_HTrans;
  logic       config_write;

  modport master (
    input  HReady, M_HResp, Bus_Grant,
    output Bus_Req, config_HTrans, config_write
  );

  modport slave (
    output HReady, M_HResp, Bus_Grant,
    input  Bus_Req, config_HTrans, config_write
  );
endinterface

// File: rtl/dmac_main_ctrl_req_arb.sv
// Fixed-priority decode of the two peripheral request lines; peripheral 2 wins.
module dmac_req_arb
  import dmac_ctrl_pkg::*;
(
  input  logic [1:0] req_i,
  output logic       req_vld_o,
  output logic       ch_sel_o
);

  // Any request is valid; bit1 set selects channel 2
  always_comb begin
    req_vld_o = |req_i;
    ch_sel_o  = req_i[1];
  end

endmodule

// File: rtl/dmac_main_ctrl.sv
// dmac_main_ctrl: request arbitration, config fetch and channel sequencing for the DMAC.
// Optional DMAC_CFG_ERR_EN: an AHB ERROR response in config fetch or transfer aborts to DONE.
module dmac_main_ctrl
  import dmac_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       DmacReq,
  input  logic             irq,
  input  logic             C_config,
  dmac_main_ctrl_if.master bus,
  output logic             DmacReq_Reg_en,
  output logic             PeriAddr_reg_en,
  output logic             SAddr_Reg_en,
  output logic             DAddr_Reg_en,
  output logic             Trans_sz_Reg_en,
  output logic             Ctrl_Reg_en,
  output logic [1:0]       addr_inc_sel,
  output logic [1:0]       con_sel,
  output logic             con_en,
  output logic             channel_en_1,
  output logic             channel_en_2,
  output logic             busy,
  output logic             dma_done,
  output logic             cfg_err
);

  dmac_state_e state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        ch_sel_q, ch_sel_d;
  logic        err_q, err_d;
  logic        req_vld_s, arb_ch_s, hresp_err_s;

  dmac_req_arb u_arb (
    .req_i     (DmacReq),
    .req_vld_o (req_vld_s),
    .ch_sel_o  (arb_ch_s)
  );

`ifdef DMAC_CFG_ERR_EN
  assign hresp_err_s = (bus.M_HResp == HRESP_ERROR);
`else
  logic unused_hresp_s;
  assign unused_hresp_s = ^bus.M_HResp;
  assign hresp_err_s    = 1'b0;
`endif

  // State, config index, latched channel and error-origin flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= CFG_IDX_SADDR;
      ch_sel_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ch_sel_q <= ch_sel_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic; err_d marks a DONE entered through an error path
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ch_sel_d = ch_sel_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_vld_s) begin
          state_d  = BUS_REQ;
          ch_sel_d = arb_ch_s;
          idx_d    = CFG_IDX_SADDR;
        end else begin
          state_d = IDLE;
        end
      end
      BUS_REQ: state_d = bus.Bus_Grant ? CFG_ADDR : BUS_REQ;
      CFG_ADDR: begin
        if (hresp_err_s) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else if (!bus.Bus_Grant) begin
          state_d = BUS_REQ;
        end else if (bus.HReady) begin
          state_d = CFG_DATA;
        end else begin
          state_d = CFG_ADDR;
        end
      end
      CFG_DATA: begin
        if (hresp_err_s) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else if (bus.HReady && (idx_q == CFG_IDX_LAST)) begin
          state_d = CHECK;
        end else if (bus.HReady) begin
          state_d = CFG_ADDR;
          idx_d   = idx_q + 2'd1;
        end else begin
          state_d = CFG_DATA;
        end
      end
      CHECK: begin
        state_d = C_config ? XFER : DONE;
        err_d   = ~C_config;
      end
      XFER: begin
        if (hresp_err_s) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else if (irq) begin
          state_d = DONE;
        end else begin
          state_d = XFER;
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = CFG_IDX_SADDR;
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode; only the capture enables look at HReady
  always_comb begin
    bus.Bus_Req       = 1'b0;
    bus.config_HTrans = HTRANS_IDLE;
    bus.config_write  = 1'b0;
    DmacReq_Reg_en    = 1'b0;
    PeriAddr_reg_en   = 1'b0;
    SAddr_Reg_en      = 1'b0;
    DAddr_Reg_en      = 1'b0;
    Trans_sz_Reg_en   = 1'b0;
    Ctrl_Reg_en       = 1'b0;
    addr_inc_sel      = CFG_IDX_SADDR;
    con_sel           = CON_SEL_CFG;
    con_en            = (state_q != IDLE);
    channel_en_1      = 1'b0;
    channel_en_2      = 1'b0;
    busy              = 1'b0;
    dma_done          = 1'b0;
    cfg_err           = 1'b0;
    case (state_q)
      IDLE: begin
        DmacReq_Reg_en  = req_vld_s;
        PeriAddr_reg_en = req_vld_s;
      end
      BUS_REQ, CHECK: begin
        bus.Bus_Req = 1'b1;
        busy        = 1'b1;
      end
      CFG_ADDR: begin
        bus.Bus_Req       = 1'b1;
        busy              = 1'b1;
        bus.config_HTrans = HTRANS_NONSEQ;
        addr_inc_sel      = idx_q;
      end
      CFG_DATA: begin
        bus.Bus_Req     = 1'b1;
        busy            = 1'b1;
        addr_inc_sel    = idx_q;
        SAddr_Reg_en    = bus.HReady && !hresp_err_s && (idx_q == CFG_IDX_SADDR);
        DAddr_Reg_en    = bus.HReady && !hresp_err_s && (idx_q == CFG_IDX_DADDR);
        Trans_sz_Reg_en = bus.HReady && !hresp_err_s && (idx_q == CFG_IDX_SIZE);
        Ctrl_Reg_en     = bus.HReady && !hresp_err_s && (idx_q == CFG_IDX_CTRL);
      end
      XFER: begin
        bus.Bus_Req  = 1'b1;
        busy         = 1'b1;
        con_sel      = ch_sel_q ? CON_SEL_CH2 : CON_SEL_CH1;
        channel_en_1 = ~ch_sel_q;
        channel_en_2 = ch_sel_q;
      end
      DONE: begin
        dma_done = ~err_q;
        cfg_err  = err_q;
      end
      default: con_sel = CON_SEL_CFG;
    endcase
  end

endmodule

// File: tb/tb_dmac_main_ctrl.sv
// Randomized scoreboard bench for dmac_main_ctrl: a transaction-level model predicts the
// ordered sequence of controller events, and a negedge monitor pops and compares them.
module tb_dmac_main_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] DmacReq;
  logic       irq, C_config;
  logic       DmacReq_Reg_en, PeriAddr_reg_en, SAddr_Reg_en, DAddr_Reg_en;
  logic       Trans_sz_Reg_en, Ctrl_Reg_en, con_en, channel_en_1, channel_en_2;
  logic       busy, dma_done, cfg_err;
  logic [1:0] addr_inc_sel, con_sel;

  dmac_main_ctrl_if bus_if ();

  dmac_main_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .DmacReq         (DmacReq),
    .irq             (irq),
    .C_config        (C_config),
    .bus             (bus_if.master),
    .DmacReq_Reg_en  (DmacReq_Reg_en),
    .PeriAddr_reg_en (PeriAddr_reg_en),
    .SAddr_Reg_en    (SAddr_Reg_en),
    .DAddr_Reg_en    (DAddr_Reg_en),
    .Trans_sz_Reg_en (Trans_sz_Reg_en),
    .Ctrl_Reg_en     (Ctrl_Reg_en),
    .addr_inc_sel    (addr_inc_sel),
    .con_sel         (con_sel),
    .con_en          (con_en),
    .channel_en_1    (channel_en_1),
    .channel_en_2    (channel_en_2),
    .busy            (busy),
    .dma_done        (dma_done),
    .cfg_err         (cfg_err)
  );

  always #5 clk = ~clk;

  // Event codes: 0 request latched, 1..4 capture of config word 0..3, 5 channel start, 6 done, 7 error
  localparam int EV_REQ = 0, EV_CAP0 = 1, EV_XFER = 5, EV_DONE = 6, EV_ERR = 7;
  typedef struct { int kind; int ch; } ev_t;
  ev_t exp_q[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_ev(input int kind, input int ch);
    ev_t e;
    e.kind = kind;
    e.ch   = ch;
    exp_q.push_back(e);
  endtask

  // Model: a transaction always latches, fetches words in order until an error, then
  // either runs the peripheral-2-priority channel and finishes, or reports an error.
  task automatic expect_txn(input logic [1:0] req, input bit cfg_ok, input int err_idx);
    int ch;
    ch = (req >= 2'd2) ? 1 : 0;
    push_ev(EV_REQ, -1);
    for (int k = 0; k < 4; k++) begin
      if (k == err_idx) begin
        push_ev(EV_ERR, -1);
        return;
      end
      push_ev(EV_CAP0 + k, -1);
    end
    if (cfg_ok) begin
      push_ev(EV_XFER, ch);
      push_ev(EV_DONE, -1);
    end else begin
      push_ev(EV_ERR, -1);
    end
  endtask

  // Monitor
  logic mon_chen;
  logic prev_chen = 1'b0;
  int   mon_n, mon_kind, cur_ch = -1;
  ev_t  mon_e;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_chen = 1'b0;
      cur_ch    = -1;
    end else begin
      mon_chen = channel_en_1 | channel_en_2;
      mon_n = int'(DmacReq_Reg_en) + int'(SAddr_Reg_en) + int'(DAddr_Reg_en) +
              int'(Trans_sz_Reg_en) + int'(Ctrl_Reg_en) + int'(mon_chen && !prev_chen) +
              int'(dma_done) + int'(cfg_err);
      if (mon_n > 1) chk("single_event", mon_n, 1);
      if (mon_n == 1) begin
        if (DmacReq_Reg_en)       mon_kind = EV_REQ;
        else if (SAddr_Reg_en)    mon_kind = EV_CAP0;
        else if (DAddr_Reg_en)    mon_kind = EV_CAP0 + 1;
        else if (Trans_sz_Reg_en) mon_kind = EV_CAP0 + 2;
        else if (Ctrl_Reg_en)     mon_kind = EV_CAP0 + 3;
        else if (mon_chen)        mon_kind = EV_XFER;
        else if (dma_done)        mon_kind = EV_DONE;
        else                      mon_kind = EV_ERR;
        if (mon_kind == EV_REQ) chk("peri_addr_en", PeriAddr_reg_en, 1);
        if (mon_kind >= EV_CAP0 && mon_kind < EV_XFER) begin
          chk("cap_con_sel", con_sel, 2);
          chk("cap_htrans", bus_if.config_HTrans, 0);
          chk("cap_hready", bus_if.HReady, 1);
          chk("cap_idx", addr_inc_sel, mon_kind - EV_CAP0);
        end
        if (mon_kind == EV_DONE || mon_kind == EV_ERR) begin
          chk("end_bus_req", bus_if.Bus_Req, 0);
          chk("end_busy", busy, 0);
          chk("cfg_write", bus_if.config_write, 0);
        end
        if (exp_q.size() == 0) begin
          chk("unexpected_event", mon_kind, -1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("event_kind", mon_kind, mon_e.kind);
          if (mon_e.kind == EV_XFER) begin
            cur_ch = mon_e.ch;
            chk("xfer_channel", channel_en_2, mon_e.ch);
          end
        end
      end
      if (mon_chen) begin
        chk("xfer_one_hot", int'(channel_en_1) + int'(channel_en_2), 1);
        chk("xfer_con_sel", con_sel, (cur_ch == 1) ? 1 : 0);
        chk("xfer_bus_req", bus_if.Bus_Req, 1);
      end
      prev_chen = mon_chen;
    end
  end

  // Driver: acts as peripheral, arbiter and slave around one transaction
  task automatic run_txn(input logic [1:0] req, input bit cfg_ok, input bit abort, input int err_idx);
    int gdly;
    int gcnt;
    bit fin;
    gdly = $urandom_range(0, 3);
    gcnt = 0;
    fin  = 1'b0;
    expect_txn(req, cfg_ok, err_idx);
    @(posedge clk); #1;
    DmacReq  = req;
    C_config = cfg_ok;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      @(posedge clk); #1;
      if (bus_if.Bus_Req) begin
        DmacReq = 2'($urandom_range(0, 3));
        gcnt++;
      end
      bus_if.Bus_Grant = bus_if.Bus_Req && (gcnt > gdly) && ($urandom_range(0, 5) != 0);
      bus_if.HReady    = ($urandom_range(0, 3) != 0);
      irq              = ($urandom_range(0, 3) == 0);
`ifdef DMAC_CFG_ERR_EN
      bus_if.M_HResp = (err_idx == 1 && busy && con_sel == 2'b10 &&
                        bus_if.config_HTrans == 2'b00 && addr_inc_sel == 2'd1) ? 2'b01 : 2'b00;
`else
      bus_if.M_HResp = 2'($urandom_range(0, 3));
`endif
      if (abort && (channel_en_1 || channel_en_2)) begin
        #2 rst = 1'b1;
        #1;
        chk("arst_ch_en", int'(channel_en_1) + int'(channel_en_2), 0);
        chk("arst_bus_req", bus_if.Bus_Req, 0);
        chk("arst_busy", busy, 0);
        chk("arst_con_sel", con_sel, 2);
        exp_q.delete();
        DmacReq = 2'b00;
        irq = 1'b0;
        bus_if.Bus_Grant = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        fin = 1'b1;
      end else if (dma_done || cfg_err) begin
        DmacReq = 2'b00;
        fin = 1'b1;
      end
    end
    if (!fin) begin
      chk("txn_timeout", 0, 1);
      rst = 1'b1;
      exp_q.delete();
      DmacReq = 2'b00;
      @(posedge clk); #1;
      rst = 1'b0;
    end
  endtask

  logic [1:0] rnd_req;

  initial begin
    rst = 1'b1;
    DmacReq = 2'b00;
    irq = 1'b0;
    C_config = 1'b0;
    bus_if.HReady = 1'b1;
    bus_if.M_HResp = 2'b00;
    bus_if.Bus_Grant = 1'b0;
    #1;
    chk("rst_con_sel", con_sel, 2);
    chk("rst_outputs", int'({bus_if.Bus_Req, busy, con_en, channel_en_1, channel_en_2,
                             dma_done, cfg_err, DmacReq_Reg_en, bus_if.config_HTrans}), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_txn(2'b01, 1'b1, 1'b0, -1);
    run_txn(2'b11, 1'b1, 1'b0, -1);
    run_txn(2'b10, 1'b0, 1'b0, -1);
    for (int t = 0; t < 30; t++) begin
      rnd_req = 2'($urandom_range(1, 3));
      run_txn(rnd_req, ($urandom_range(0, 3) != 0), 1'b0, -1);
    end
    run_txn(2'b01, 1'b1, 1'b1, -1);
    run_txn(2'b10, 1'b1, 1'b0, -1);
`ifdef DMAC_CFG_ERR_EN
    run_txn(2'b01, 1'b1, 1'b0, 1);
`endif
    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
